// File: rtl/riscv_pkg.sv
// Shared types and widths for the integer pipeline's writeback side.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; requester 0 maps to GRANT_ALU, 1 to GRANT_MEM.
// Grant is combinational from the requests and the registered last winner.
module rr_arbiter2
  import riscv_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  grant_t last_q;
  grant_t last_d;

  // Requester 0 wins when alone, or on contention when 1 won most recently.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (req_i[0] && (!req_i[1] || last_q == GRANT_MEM)) begin
      gnt_o[0] = 1'b1;
      last_d   = GRANT_ALU;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
      last_d   = GRANT_MEM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= GRANT_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and load results onto the single register file write port and
// tracks outstanding destinations in a busy scoreboard for decode stalls.
module reg_writeback #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     alu_valid,
  input  logic [$clog2(NREGS)-1:0] alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [$clog2(NREGS)-1:0] mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     mem_ready,
  input  logic [$clog2(NREGS)-1:0] read_reg_num1,
  input  logic [$clog2(NREGS)-1:0] read_reg_num2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [$clog2(NREGS)-1:0] write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic                     regwrite,
  output logic                     wb_error
);

  import riscv_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [1:0]      gnt;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic [NREGS-1:0] busy_q,       busy_d;
  logic             regwrite_q,   regwrite_d;
  logic [AW-1:0]    write_reg_q,  write_reg_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;
  logic             wb_error_q,   wb_error_d;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req_i ({mem_valid, alu_valid}),
    .gnt_o (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign accept    = |gnt;
  assign sel_rd    = gnt[1] ? mem_rd   : alu_rd;
  assign sel_data  = gnt[1] ? mem_data : alu_data;

  // x0 results are consumed but never reach the register file.
  always_comb begin
    regwrite_d   = accept && (sel_rd != '0);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    wb_error_d   = wb_error_q;
    if (regwrite_d) begin
      write_reg_d  = sel_rd;
      write_data_d = sel_data;
      if (!busy_q[sel_rd]) begin
        wb_error_d = 1'b1;
      end
    end
  end

  // Clearing on the committing cycle keeps busy high until the data has landed;
  // a same-cycle reissue keeps the bit set for the new producer.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = issue_valid && (issue_rd == AW'(gi));
        assign clr_hit    = regwrite_q && (write_reg_q == AW'(gi));
        assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q       <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wb_error_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wb_error_q   <= wb_error_d;
    end
  end

  assign busy1      = busy_q[read_reg_num1];
  assign busy2      = busy_q[read_reg_num2];
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign regwrite   = regwrite_q;
  assign wb_error   = wb_error_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a per-cycle reference model and
// hand-computed checkpoints.
module tb_reg_writeback;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  read_reg_num1;
  logic [4:0]  read_reg_num2;
  logic        busy1;
  logic        busy2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regwrite;
  logic        wb_error;

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback dut (
    .clock         (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .busy1         (busy1),
    .busy2         (busy2),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .regwrite      (regwrite),
    .wb_error      (wb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Who is served this cycle: {mem, alu}. last_mem=1 means MEM won most recently.
  function automatic logic [1:0] exp_grant(input logic av, input logic mv, input logic last_mem);
    if (av && mv) return last_mem ? 2'b01 : 2'b10;
    if (av)       return 2'b01;
    if (mv)       return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: scoreboard as a plain bit array, write port as a register.
  logic [31:0] m_busy;
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic        m_err;
  logic        m_last_mem;

  always @(posedge clk) begin : model
    logic [31:0] nb;
    logic [1:0]  g;
    logic [4:0]  rd;
    logic [31:0] d;
    if (reset) begin
      m_busy     <= '0;
      m_rw       <= 1'b0;
      m_wreg     <= '0;
      m_wdata    <= '0;
      m_err      <= 1'b0;
      m_last_mem <= 1'b1;
    end else begin
      nb = m_busy;
      if (m_rw) nb[m_wreg] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      g = exp_grant(alu_valid, mem_valid, m_last_mem);
      m_rw <= 1'b0;
      if (g != 2'b00) begin
        rd = g[0] ? alu_rd   : mem_rd;
        d  = g[0] ? alu_data : mem_data;
        m_last_mem <= g[1];
        if (rd != 5'd0) begin
          m_rw    <= 1'b1;
          m_wreg  <= rd;
          m_wdata <= d;
          if (!m_busy[rd]) m_err <= 1'b1;
        end
      end
      m_busy <= nb;
    end
  end

  // Compare on every falling edge once the first reset edge has passed.
  initial begin : compare
    logic [1:0] eg;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = exp_grant(alu_valid, mem_valid, m_last_mem);
      check("alu_ready",  {31'd0, alu_ready}, {31'd0, eg[0]});
      check("mem_ready",  {31'd0, mem_ready}, {31'd0, eg[1]});
      check("regwrite",   {31'd0, regwrite},  {31'd0, m_rw});
      check("write_reg",  {27'd0, write_reg}, {27'd0, m_wreg});
      check("write_data", write_data, m_wdata);
      check("wb_error",   {31'd0, wb_error},  {31'd0, m_err});
      check("busy1",      {31'd0, busy1},     {31'd0, m_busy[read_reg_num1]});
      check("busy2",      {31'd0, busy2},     {31'd0, m_busy[read_reg_num2]});
      if (regwrite)
        $display("wb: reg x%0d <= %08h  (alu_rdy=%0b mem_rdy=%0b err=%0b)",
                 write_reg, write_data, alu_ready, mem_ready, wb_error);
    end
  end

  logic [4:0] scan = 5'd0;

  task automatic tick();
    @(posedge clk);
    #2;
    scan          = scan + 5'd1;
    read_reg_num1 = scan;
    read_reg_num2 = scan + 5'd16;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid   = 1'b0; alu_rd   = 5'd0; alu_data = 32'd0;
    mem_valid   = 1'b0; mem_rd   = 5'd0; mem_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin : stim
    int  ai, mi;
    logic was_alu;
    idle();
    read_reg_num1 = 5'd0;
    read_reg_num2 = 5'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_wb_error", {31'd0, wb_error}, 32'd0);
    check("rst_write_data", write_data, 32'd0);

    // Single ALU writeback
    issue(5'd5);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    read_reg_num1 = 5'd5;
    #1;
    check("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("single_busy5_set", {31'd0, busy1}, 32'd1);
    tick();
    idle();
    read_reg_num1 = 5'd5;
    #1;
    check("single_regwrite", {31'd0, regwrite}, 32'd1);
    check("single_write_reg", {27'd0, write_reg}, 32'd5);
    check("single_write_data", write_data, 32'hDEADBEEF);
    check("single_busy5_still", {31'd0, busy1}, 32'd1);
    tick();
    read_reg_num1 = 5'd5;
    #1;
    check("single_busy5_clear", {31'd0, busy1}, 32'd0);
    check("single_hold_data", write_data, 32'hDEADBEEF);
    check("single_regwrite_low", {31'd0, regwrite}, 32'd0);

    // Contention right after reset: ALU first, then MEM
    reset = 1'b1; tick(); reset = 1'b0;
    issue(5'd3);
    issue(5'd4);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
    #1;
    check("cont_first_alu", {30'd0, mem_ready, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    check("cont_then_mem", {31'd0, mem_ready}, 32'd1);
    check("cont_wr3", {27'd0, write_reg}, 32'd3);
    tick();
    idle();
    check("cont_wr4", {27'd0, write_reg}, 32'd4);
    check("cont_data4", write_data, 32'h0000_0044);
    check("cont_no_err", {31'd0, wb_error}, 32'd0);
    tick();

    // Sustained contention, fresh result after each grant
    for (int i = 10; i < 18; i++) issue(5'(i));
    ai = 0; mi = 0;
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + 2 * ai); alu_data = 32'hA000_0000 | 32'(alu_rd);
      mem_valid = 1'b1; mem_rd = 5'(11 + 2 * mi); mem_data = 32'hB000_0000 | 32'(mem_rd);
      #1;
      check($sformatf("rr_alu_%0d", k), {31'd0, alu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_mem_%0d", k), {31'd0, mem_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      was_alu = alu_ready;
      tick();
      if (was_alu) ai++; else mi++;
    end
    idle();
    check("rr_last_wr", {27'd0, write_reg}, 32'd17);
    tick(); tick();
    check("rr_no_err", {31'd0, wb_error}, 32'd0);

    // Set/clear collision on x7
    issue(5'd7);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    read_reg_num1 = 5'd7;
    #1;
    check("collide_busy7", {31'd0, busy1}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
    tick();
    idle();
    tick();
    read_reg_num1 = 5'd7;
    #1;
    check("collide_busy7_done", {31'd0, busy1}, 32'd0);

    // x0 result: consumed, never written
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    check("x0_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    idle();
    read_reg_num1 = 5'd0;
    #1;
    check("x0_regwrite", {31'd0, regwrite}, 32'd0);
    check("x0_busy", {31'd0, busy1}, 32'd0);
    check("x0_no_err", {31'd0, wb_error}, 32'd0);

    // MEM result to a never-issued register
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0999;
    tick();
    idle();
    check("err_write", {31'd0, regwrite}, 32'd1);
    check("err_reg", {27'd0, write_reg}, 32'd9);
    check("err_set", {31'd0, wb_error}, 32'd1);
    tick(); tick();
    check("err_sticky", {31'd0, wb_error}, 32'd1);

    // Reset mid-stream with busy = 0x0F00 and a grant pending
    for (int r = 8; r < 12; r++) issue(5'(r));
    for (int r = 8; r < 12; r++) begin
      read_reg_num1 = 5'(r);
      #1;
      check($sformatf("pre_rst_busy%0d", r), {31'd0, busy1}, 32'd1);
    end
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_0888;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0999;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_mid_err", {31'd0, wb_error}, 32'd0);
    for (int r = 8; r < 12; r++) begin
      read_reg_num1 = 5'(r);
      #1;
      check($sformatf("rst_mid_busy%0d", r), {31'd0, busy1}, 32'd0);
    end
    check("rst_mid_alu_wins", {30'd0, mem_ready, alu_ready}, 32'd1);
    tick();
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
